// File: rtl/multi_tick_generator_if.sv
// multi_tick_generator_if: control and tick/square outputs of the multi-channel tick generator.
interface multi_tick_generator_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0] en;
    logic              restart;
    logic [NUM_CH-1:0] div_wr;
    logic [CNT_W-1:0]  div_wdata;
    logic              mode_wdata;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] sq_o;
    logic [NUM_CH-1:0] div_pending;

    modport master (
        output en, restart, div_wr, div_wdata, mode_wdata,
        input  tick_o, sq_o, div_pending
    );

    modport slave (
        input  en, restart, div_wr, div_wdata, mode_wdata,
        output tick_o, sq_o, div_pending
    );
endinterface

// File: rtl/multi_tick_generator.sv
// multi_tick_generator: per-channel programmable clock-enable ticks and 50% square waves
// with shadowed divisors that only take effect at a wrap, so no runt period is ever produced.
module multi_tick_generator #(
    parameter int               NUM_CH   = 2,
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] DEF_DIV  = 320,
    parameter bit               DEF_MODE = 1'b0
) (
    input logic                   clk,
    input logic                   rst_n,
    multi_tick_generator_if.slave bus
);
    logic [CNT_W-1:0]  r_cnt     [NUM_CH];
    logic [CNT_W-1:0]  r_div_act [NUM_CH];
    logic [CNT_W-1:0]  r_div_shd [NUM_CH];
    logic [NUM_CH-1:0] r_mode, r_mode_shd, r_armed, r_pend, r_tick, r_sq;
    logic [NUM_CH-1:0] w_wrap, w_apply, w_load;

    // A pending shadow may only land where the old period ends (wrap), when the channel is stopped, or on restart.
    always_comb begin
        w_wrap  = '0;
        w_apply = '0;
        w_load  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wrap[i]  = bus.en[i] && r_armed[i] && (r_cnt[i] == r_div_act[i]);
            w_apply[i] = bus.restart || !bus.en[i] || (r_armed[i] && (r_cnt[i] == r_div_act[i]));
            w_load[i]  = w_apply[i] && (r_pend[i] || bus.div_wr[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]     <= '0;
                r_div_act[i] <= DEF_DIV;
                r_div_shd[i] <= DEF_DIV;
            end
            r_mode     <= {NUM_CH{DEF_MODE}};
            r_mode_shd <= {NUM_CH{DEF_MODE}};
            r_armed    <= '1;
            r_pend     <= '0;
            r_tick     <= '0;
            r_sq       <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.restart) begin
                    r_cnt[i]   <= '0;
                    r_tick[i]  <= 1'b0;
                    r_sq[i]    <= 1'b0;
                    r_armed[i] <= 1'b1;
                end else if (w_wrap[i]) begin
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b1;
                    r_sq[i]   <= !r_sq[i];
                    if (r_mode[i])
                        r_armed[i] <= 1'b0;
                end else begin
                    r_tick[i] <= 1'b0;
                    if (bus.en[i] && r_armed[i])
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                // A write coinciding with the load point bypasses the shadow.
                if (w_load[i]) begin
                    r_div_act[i] <= bus.div_wr[i] ? bus.div_wdata : r_div_shd[i];
                    r_mode[i]    <= bus.div_wr[i] ? bus.mode_wdata : r_mode_shd[i];
                    r_armed[i]   <= 1'b1;
                end
                if (bus.div_wr[i]) begin
                    r_div_shd[i]  <= bus.div_wdata;
                    r_mode_shd[i] <= bus.mode_wdata;
                end
                r_pend[i] <= !w_apply[i] && (r_pend[i] || bus.div_wr[i]);
            end
        end
    end

    assign bus.tick_o      = r_tick;
    assign bus.sq_o        = r_sq;
    assign bus.div_pending = r_pend;
endmodule

// File: tb/tb_multi_tick_generator.sv
// tb_multi_tick_generator: directed scenarios plus random traffic checked cycle by cycle
// against a period/phase reference model of each channel.
module tb_multi_tick_generator;
    localparam int N = 2;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_tick_generator_if #(.NUM_CH(N), .CNT_W(W)) bus ();

    multi_tick_generator #(
        .NUM_CH(N), .CNT_W(W), .DEF_DIV(16'd320), .DEF_MODE(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: a channel is a period (div+1) and a phase within it; the square wave is the parity of completed periods.
    int m_period [N];
    int m_phase  [N];
    int m_wraps  [N];
    int m_sdiv   [N];
    bit m_oneshot[N];
    bit m_done   [N];
    bit m_pend   [N];
    bit m_smode  [N];
    bit m_tick   [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < N; c++) begin
            m_period[c]  = 321;
            m_phase[c]   = 0;
            m_wraps[c]   = 0;
            m_sdiv[c]    = 320;
            m_oneshot[c] = 1'b0;
            m_done[c]    = 1'b0;
            m_pend[c]    = 1'b0;
            m_smode[c]   = 1'b0;
            m_tick[c]    = 1'b0;
        end
    endfunction

    function automatic void m_step();
        for (int c = 0; c < N; c++) begin
            bit run, wrap, ld;
            run  = bus.en[c] && !m_done[c];
            wrap = run && (m_phase[c] == m_period[c] - 1);
            ld   = bus.restart || wrap || !bus.en[c];
            if (bus.div_wr[c]) begin
                m_sdiv[c]  = int'(bus.div_wdata);
                m_smode[c] = bus.mode_wdata;
                m_pend[c]  = 1'b1;
            end
            if (bus.restart) begin
                m_phase[c] = 0;
                m_tick[c]  = 1'b0;
                m_wraps[c] = 0;
                m_done[c]  = 1'b0;
            end else if (wrap) begin
                m_phase[c] = 0;
                m_tick[c]  = 1'b1;
                m_wraps[c]++;
                if (m_oneshot[c]) m_done[c] = 1'b1;
            end else begin
                m_tick[c] = 1'b0;
                if (run) m_phase[c]++;
            end
            if (ld && m_pend[c]) begin
                m_period[c]  = m_sdiv[c] + 1;
                m_oneshot[c] = m_smode[c];
                m_done[c]    = 1'b0;
                m_pend[c]    = 1'b0;
            end
        end
    endfunction

    task automatic check_out(input string tag);
        logic [N-1:0] et, es, ep;
        for (int c = 0; c < N; c++) begin
            et[c] = m_tick[c];
            es[c] = m_wraps[c][0];
            ep[c] = m_pend[c];
        end
        chk({tag, ".tick"}, 32'(bus.tick_o), 32'(et));
        chk({tag, ".sq"}, 32'(bus.sq_o), 32'(es));
        chk({tag, ".pend"}, 32'(bus.div_pending), 32'(ep));
    endtask

    task automatic step(input logic [N-1:0] en, input logic rs, input logic [N-1:0] wr,
                        input int wd, input bit md, input string tag);
        bus.en         = en;
        bus.restart    = rs;
        bus.div_wr     = wr;
        bus.div_wdata  = W'(wd);
        bus.mode_wdata = md;
        @(posedge clk);
        m_step();
        #1 check_out(tag);
    endtask

    task automatic run(input int n, input logic [N-1:0] en, input string tag);
        for (int k = 0; k < n; k++) step(en, 1'b0, '0, 0, 1'b0, tag);
    endtask

    task automatic measure(input int ch, input logic [N-1:0] en, output int n);
        n = 0;
        do begin
            step(en, 1'b0, '0, 0, 1'b0, "t1");
            n++;
        end while (!bus.tick_o[ch] && n < 1000);
    endtask

    initial begin
        int lat;
        bus.en = '0; bus.restart = 1'b0; bus.div_wr = '0; bus.div_wdata = '0; bus.mode_wdata = 1'b0;
        m_reset();
        #2 check_out("reset");
        #10 rst_n = 1'b1;
        measure(0, 2'b01, lat);
        chk("t1.first_lat", 32'(lat), 32'd321);
        measure(0, 2'b01, lat);
        chk("t1.period", 32'(lat), 32'd321);
        run(330, 2'b01, "t1.sq");
        step(2'b01, 1'b0, 2'b10, 0, 1'b0, "t2.wr");
        run(6, 2'b11, "t2");
        step(2'b11, 1'b1, 2'b01, 9, 1'b0, "t3.rs");
        run(5, 2'b11, "t3");
        step(2'b11, 1'b0, 2'b01, 3, 1'b0, "t3.wr");
        run(14, 2'b11, "t3");
        step(2'b11, 1'b0, 2'b01, 9, 1'b0, "t4.wr9");
        step(2'b11, 1'b0, 2'b01, 4, 1'b0, "t4.wr4");
        run(12, 2'b11, "t4");
        step(2'b11, 1'b1, '0, 0, 1'b0, "t5.rs");
        run(3, 2'b11, "t5");
        run(7, 2'b10, "t5.off");
        run(12, 2'b11, "t5");
        step(2'b11, 1'b1, 2'b01, 5, 1'b1, "t6.rs");
        run(20, 2'b11, "t6");
        step(2'b11, 1'b1, '0, 0, 1'b0, "t6.rs2");
        run(9, 2'b11, "t6");
        #2 rst_n = 1'b0;
        m_reset();
        #1 check_out("async_rst");
        @(posedge clk);
        #1 check_out("rst_hold");
        rst_n = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] en, wr;
            for (int c = 0; c < N; c++) begin
                en[c] = $urandom_range(0, 9) != 0;
                wr[c] = $urandom_range(0, 29) == 0;
            end
            step(en, $urandom_range(0, 99) == 0, wr, int'($urandom_range(0, 12)),
                 $urandom_range(0, 4) == 0, "rnd");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
